// File: rtl/branch_resolve_unit.sv
// Purpose : resolves execute-stage branches/jumps from SUB flags and redirects Fetch on a mispredict.
// Latency : redirect/flush registered, visible the cycle after the mispredict edge; TakenE is combinational.
// Backpress: RedirectValid/RedirectPC hold steady until RedirectReady; BusyE stalls Execute until then.
//
// Ports:
//   clk, reset                      - core clock, asynchronous active-high reset
//   ValidE, BranchTypeE             - control-flow op present in Execute and its kind
//   Zero, oVerflow, Negative, Carry - ALU flags of OpA-OpB (Carry = borrow)
//   PredTakenE, PCTargetE, PCPlus4E - fetch prediction, taken target, fall-through
//   RedirectValid/Ready/PC          - registered redirect handshake to Fetch
//   FlushDE, BusyE, TakenE          - decode/execute flush, execute stall, debug taken
//   BranchCount, MispredictCount    - saturating statistics, present only with BRANCH_STATS_EN
//
// Optional feature macro: BRANCH_STATS_EN (statistics counters and their ports).

`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_resolve_unit #(
  parameter int STATS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ValidE,
  input  logic [3:0]             BranchTypeE,
  input  logic                   Zero,
  input  logic                   oVerflow,
  input  logic                   Negative,
  input  logic                   Carry,
  input  logic                   PredTakenE,
  input  logic [`BIT_COUNT-1:0]  PCTargetE,
  input  logic [`BIT_COUNT-1:0]  PCPlus4E,
  output logic                   RedirectValid,
  input  logic                   RedirectReady,
  output logic [`BIT_COUNT-1:0]  RedirectPC,
  output logic                   FlushDE,
  output logic                   BusyE,
  output logic                   TakenE
`ifdef BRANCH_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] BranchCount,
  output logic [STATS_WIDTH-1:0] MispredictCount
`endif
);

  localparam logic [3:0] BT_NONE = 4'd0;
  localparam logic [3:0] BT_BEQ  = 4'd1;
  localparam logic [3:0] BT_BNE  = 4'd2;
  localparam logic [3:0] BT_BLT  = 4'd3;
  localparam logic [3:0] BT_BGE  = 4'd4;
  localparam logic [3:0] BT_BLTU = 4'd5;
  localparam logic [3:0] BT_BGEU = 4'd6;
  localparam logic [3:0] BT_JAL  = 4'd7;
  localparam logic [3:0] BT_JALR = 4'd8;

  // Encoding chosen so bit 0 is RedirectValid/BusyE and bit 1 is FlushDE:
  // every handshake output comes straight off a flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    REQ  = 2'b11
  } state_t;

  state_t                  state, state_nxt;
  logic                    taken;
  logic                    is_branch;
  logic                    mispredict;
  logic                    lt;
  logic [`BIT_COUNT-1:0]   pc_q;

  // Signed less-than from SUB flags.
  assign lt = Negative ^ oVerflow;

  // Condition decode; illegal codes behave exactly like NONE.
  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (BranchTypeE)
      BT_BEQ:  taken = Zero;
      BT_BNE:  taken = ~Zero;
      BT_BLT:  taken = lt;
      BT_BGE:  taken = ~lt;
      BT_BLTU: taken = Carry;
      BT_BGEU: taken = ~Carry;
      BT_JAL:  taken = 1'b1;
      BT_JALR: taken = 1'b1;
      default: begin
        taken     = 1'b0;
        is_branch = 1'b0;
      end
    endcase
  end

  assign TakenE     = taken;
  assign mispredict = ValidE & ~BusyE & is_branch & (taken != PredTakenE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispredict) state_nxt = REQ;
      REQ:     state_nxt = RedirectReady ? IDLE : HOLD;
      HOLD:    if (RedirectReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state bits (no logic between flop and port).
  always_comb begin
    RedirectValid = state[0];
    BusyE         = state[0];
    FlushDE       = state[1];
  end

  // Corrected PC is captured only at the mispredict edge, which can only
  // happen in IDLE, so it stays frozen for the whole REQ/HOLD window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc_q <= '0;
    else if (mispredict) pc_q <= taken ? PCTargetE : PCPlus4E;
  end

  assign RedirectPC = pc_q;

`ifdef BRANCH_STATS_EN
  logic [STATS_WIDTH-1:0] br_cnt, mp_cnt;

  // BusyE is low exactly when IDLE, so ~BusyE doubles as the "sampled" qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (ValidE && !BusyE && is_branch && (br_cnt != {STATS_WIDTH{1'b1}}))
        br_cnt <= br_cnt + 1'b1;
      if (mispredict && (mp_cnt != {STATS_WIDTH{1'b1}}))
        mp_cnt <= mp_cnt + 1'b1;
    end
  end

  assign BranchCount     = br_cnt;
  assign MispredictCount = mp_cnt;
`else
  logic unused_stats_cfg;
  assign unused_stats_cfg = (STATS_WIDTH > 0);
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && ValidE && !BusyE)
      assert (BranchTypeE <= BT_JALR)
        else $error("branch_resolve_unit: illegal BranchTypeE %0d", BranchTypeE);
  end
`endif

endmodule
